// File: rtl/sa_skew_feeder.sv
//==============================================================================
// Module      : sa_skew_feeder
// Description : Upstream input stage of the systolic array. Accepts one row
//               vector of an operand tile per beat and emits lane k of that
//               row k cycles after lane 0 (diagonal skew). Frames tiles by
//               blocking input while the skew pipe drains after the last row,
//               then pulses tile-done. Idle lanes carry zero with valid low.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sa_skew_feeder #(
    parameter int WIDTH    = 16,
    parameter int N        = 4,
    parameter int MAX_ROWS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic                 i_last,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         o_vld,
    output logic [N*WIDTH-1:0]   out_data,
    output logic                 o_tile_done,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int c_cnt_w = $clog2(MAX_ROWS + 1);
    localparam int c_drn_w = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_stream = 2'd1;
    localparam logic [1:0] c_drain  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_row_cnt;
    logic [c_drn_w-1:0] r_drn_cnt;
    logic               r_err;

    logic w_accept;
    logic w_at_limit;
    logic w_force;
    logic w_close;
    logic w_drn_end;

    assign w_accept   = i_vld && i_rdy;
    // The row that would make the count reach MAX_ROWS closes the tile even
    // without i_last; it still travels through the lanes like any other row.
    assign w_at_limit = (r_row_cnt == c_cnt_w'(MAX_ROWS - 1));
    assign w_force    = w_accept && !i_last && w_at_limit;
    assign w_close    = w_accept && (i_last || w_at_limit);
    // Final DRAIN cycle coincides with the tile's last row leaving lane N-1.
    assign w_drn_end  = (r_state == c_drain) && (r_drn_cnt == c_drn_w'(N - 1));

    // Ready depends on state only so the source never sees a vld->rdy path.
    assign i_rdy       = (r_state != c_drain);
    assign o_busy      = (r_state != c_idle);
    assign o_tile_done = w_drn_end;
    assign o_err       = r_err;

    // Tile framing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: open a tile on first row, drain after the closing row.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle, c_stream: begin
                if (w_close) begin
                    w_state_nxt = c_drain;
                end else if (w_accept) begin
                    w_state_nxt = c_stream;
                end
            end
            c_drain: begin
                if (w_drn_end) begin
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // Rows accepted in the current tile; restarts when the tile closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_cnt <= '0;
        end else if (w_close) begin
            r_row_cnt <= '0;
        end else if (w_accept) begin
            r_row_cnt <= r_row_cnt + 1'b1;
        end
    end

    // Cycles spent in DRAIN; held at zero outside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drn_cnt <= '0;
        end else if (r_state != c_drain) begin
            r_drn_cnt <= '0;
        end else begin
            r_drn_cnt <= r_drn_cnt + 1'b1;
        end
    end

    // One-cycle error pulse after a force-closing accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_force;
        end
    end

    // Per-lane skew chains of depth k+1 carrying {vld, data}.
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [WIDTH:0] r_pipe [0:k];

        // Shift a new element (or a zero bubble) into lane k every cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= k; s++) begin
                    r_pipe[s] <= '0;
                end
            end else begin
                r_pipe[0] <= w_accept ? {1'b1, in_data[k*WIDTH +: WIDTH]} : '0;
                for (int s = 1; s <= k; s++) begin
                    r_pipe[s] <= r_pipe[s-1];
                end
            end
        end

        assign o_vld[k]                   = r_pipe[k][WIDTH];
        assign out_data[k*WIDTH +: WIDTH] = r_pipe[k][WIDTH-1:0];
    end

endmodule

`default_nettype wire

// File: tb/tb_sa_skew_feeder.sv
//==============================================================================
// Module      : tb_sa_skew_feeder
// Description : Self-checking bench for sa_skew_feeder. A cycle-indexed
//               reference model records accepted rows and tile boundaries and
//               derives every output from arithmetic on accept cycles.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sa_skew_feeder;

    localparam int WIDTH    = 16;
    localparam int N        = 4;
    localparam int MAX_ROWS = 16;
    localparam int OW       = 4 + N + N*WIDTH;
    localparam int HIST     = 64;
    localparam logic [OW-1:0] RST_VEC = {1'b1, {(OW-1){1'b0}}};

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_vld = 1'b0;
    logic               i_last = 1'b0;
    logic [N*WIDTH-1:0] in_data = '0;
    logic               i_rdy;
    logic [N-1:0]       o_vld;
    logic [N*WIDTH-1:0] out_data;
    logic               o_tile_done;
    logic               o_busy;
    logic               o_err;

    logic [OW-1:0] obs_vec;
    assign obs_vec = {i_rdy, o_busy, o_tile_done, o_err, o_vld, out_data};

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    sa_skew_feeder #(.WIDTH(WIDTH), .N(N), .MAX_ROWS(MAX_ROWS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vld       (i_vld),
        .i_rdy       (i_rdy),
        .i_last      (i_last),
        .in_data     (in_data),
        .o_vld       (o_vld),
        .out_data    (out_data),
        .o_tile_done (o_tile_done),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    // Reference model: cycle c's outputs come from rows accepted at c-1-k;
    // a tile closed at cycle t blocks input for t+1..t+N, done at t+N.
    int                 cyc = 100;
    bit                 acc_v [HIST];
    logic [N*WIDTH-1:0] acc_d [HIST];
    int                 drn_lo = -1000;
    int                 drn_hi = -1000;
    int                 err_at = -1000;
    int                 rows   = 0;
    bit                 open_t = 1'b0;
    bit                 acc_now = 1'b0;
    logic [OW-1:0]      exp_vec = RST_VEC;

    always @(negedge clk) begin : model
        logic [N-1:0]       ev;
        logic [N*WIDTH-1:0] ed;
        bit                 rdy;
        int                 idx;
        cyc++;
        if (!rst_n) begin
            for (int h = 0; h < HIST; h++) acc_v[h] = 1'b0;
            drn_lo = -1000; drn_hi = -1000; err_at = -1000;
            rows = 0; open_t = 1'b0; acc_now = 1'b0;
            exp_vec = RST_VEC;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (cyc - 1 - k) % HIST;
                ev[k] = acc_v[idx];
                ed[k*WIDTH +: WIDTH] = acc_v[idx] ? acc_d[idx][k*WIDTH +: WIDTH] : '0;
            end
            rdy = !(cyc >= drn_lo && cyc <= drn_hi);
            exp_vec = {rdy, open_t || !rdy, cyc == drn_hi, cyc == err_at, ev, ed};
            acc_now = i_vld && rdy;
            acc_v[cyc % HIST] = acc_now;
            acc_d[cyc % HIST] = in_data;
            if (acc_now) begin
                rows++;
                if (i_last || rows == MAX_ROWS) begin
                    drn_lo = cyc + 1;
                    drn_hi = cyc + N;
                    if (!i_last) err_at = cyc + 1;
                    rows = 0;
                    open_t = 1'b0;
                end else begin
                    open_t = 1'b1;
                end
            end
        end
    end

    function automatic logic [N*WIDTH-1:0] rnd_row();
        logic [N*WIDTH-1:0] r;
        for (int k = 0; k < N; k++) r[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return r;
    endfunction

    // Drive one cycle of input and move to the sampling point of that cycle.
    task automatic send(input bit v, input bit l, input logic [N*WIDTH-1:0] d);
        @(posedge clk); #1;
        i_vld = v; i_last = l; in_data = d;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_vec++;
            if (obs_vec !== RST_VEC) begin
                n_miss++;
                $display("FAIL reset_const cyc=%0d got=%h want=%h", cyc, obs_vec, RST_VEC);
            end
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [N*WIDTH-1:0] row;
        row = {16'd4, 16'd3, 16'd2, 16'd1};
        for (int i = 0; i < 6; i++) begin
            send(i == 0, i == 0, (i == 0) ? row : rnd_row());
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            if (i == 1) begin
                n_vec++;
                if (o_vld !== 4'b0001 || out_data[WIDTH-1:0] !== 16'd1 || i_rdy !== 1'b0) begin
                    n_miss++;
                    $display("FAIL single_lane0 vld=%b lane0=%0d rdy=%b want vld=0001 lane0=1 rdy=0",
                             o_vld, out_data[WIDTH-1:0], i_rdy);
                end
            end
            if (i == 4) begin
                n_vec++;
                if (o_vld !== 4'b1000 || out_data[3*WIDTH +: WIDTH] !== 16'd4 || o_tile_done !== 1'b1) begin
                    n_miss++;
                    $display("FAIL single_lane3 vld=%b lane3=%0d done=%b want vld=1000 lane3=4 done=1",
                             o_vld, out_data[3*WIDTH +: WIDTH], o_tile_done);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int v3 = 0;
        int dn = 0;
        for (int i = 0; i < 10; i++) begin
            send(i < 4, i == 3, rnd_row());
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            v3 += int'(o_vld[N-1]);
            dn += int'(o_tile_done);
        end
        n_vec++;
        if (v3 != 4 || dn != 1) begin
            n_miss++;
            $display("FAIL b2b_counts lane3_vld=%0d done=%0d want 4 and 1", v3, dn);
        end
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 8; i++) begin
            send(i == 0 || i == 2, i == 2, rnd_row());
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL bubbles cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N*WIDTH-1:0] held;
        int t0 = 0;
        int ta = -1;
        send(1'b1, 1'b1, rnd_row());
        t0 = cyc;
        n_vec++;
        if (obs_vec !== exp_vec) begin
            n_miss++;
            $display("FAIL bp_first cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
        end
        held = rnd_row();
        for (int i = 0; i < 20 && ta < 0; i++) begin
            send(1'b1, 1'b1, held);
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            if (acc_now) ta = cyc;
        end
        n_vec++;
        if (ta != t0 + N + 1) begin
            n_miss++;
            $display("FAIL bp_accept_cycle got=%0d want=%0d", ta - t0, N + 1);
        end
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 1'b0, rnd_row());
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL bp_drain cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_overflow();
        int t16 = 0;
        int e_c = -1;
        int d_c = -1;
        for (int i = 0; i < MAX_ROWS + 7; i++) begin
            send(i < MAX_ROWS, 1'b0, rnd_row());
            if (i == MAX_ROWS - 1) t16 = cyc;
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL overflow cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            if (o_err === 1'b1) e_c = cyc;
            if (o_tile_done === 1'b1) d_c = cyc;
        end
        n_vec++;
        if (e_c != t16 + 1 || d_c != t16 + N) begin
            n_miss++;
            $display("FAIL overflow_timing err_off=%0d done_off=%0d want 1 and %0d", e_c - t16, d_c - t16, N);
        end
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, rnd_row());
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL rstmid_load cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b0; i_vld = 1'b0;
        #1;
        n_vec++;
        if (obs_vec !== RST_VEC) begin
            n_miss++;
            $display("FAIL rstmid_async got=%h want=%h", obs_vec, RST_VEC);
        end
        @(negedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 1'b0, rnd_row());
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL rstmid_after cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            dn += int'(o_tile_done);
        end
        n_vec++;
        if (dn != 0) begin
            n_miss++;
            $display("FAIL rstmid_done got=%0d pulses want 0", dn);
        end
    endtask

    task automatic test_random();
        bit                 have = 1'b0;
        bit                 last = 1'b0;
        logic [N*WIDTH-1:0] row = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have) begin
                have = ($urandom_range(9) < 7);
                last = ($urandom_range(4) == 0);
                row  = rnd_row();
            end
            send(have, have ? last : 1'($urandom), have ? row : rnd_row());
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
            if (acc_now) have = 1'b0;
        end
        for (int i = 0; i < MAX_ROWS + N + 2; i++) begin
            send(1'b0, 1'b0, rnd_row());
            n_vec++;
            if (obs_vec !== exp_vec) begin
                n_miss++;
                $display("FAIL random_tail cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bubbles();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
